// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions raw, bouncing button/switch inputs into clean control signals.
//   Each button path is fully independent:
//     2-flop synchronizer -> debounce counter -> debounced level
//     rising edge of level -> one-cycle press pulse
//     repeat FSM -> press pulse followed by auto-repeat pulses while held
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | button released (or auto-repeat disabled); rcnt held at 0
//   HOLD  | pressed, counting REPEAT_DELAY cycles to first auto-repeat
//   RPT   | auto-repeating, one pulse every REPEAT_PERIOD cycles
//
// Ports
//   clk        : system clock, all state changes on rising edge
//   reset      : synchronous, active-high reset
//   btn_in     : raw asynchronous button levels, 1 = pressed
//   btn_level  : debounced level per button
//   btn_pulse  : one-cycle pulse per accepted press
//   btn_repeat : one-cycle pulse on press, then auto-repeat while held
module button_conditioner #(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 50000000,
  parameter int               REPEAT_PERIOD   = 20000000,
  parameter logic [N_BTN-1:0] REPEAT_EN       = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RC_W    = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_TC = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_TC = RC_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RPT  = 2'd2;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DB_W-1:0] dcnt_q, dcnt_d;
    logic            level_q, level_d;
    logic            rise;
    logic [1:0]      state_q, state_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic            rep_d;
    logic            pulse_q, rep_q;

    // Counter runs only while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      if (s2_q[i] != level_q) begin
        if (dcnt_q == DB_TC) begin
          level_d = s2_q[i];
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    assign rise = level_d & ~level_q;

    // The FSM looks at the next level so a release landing on the same edge
    // as a terminal count suppresses that repeat pulse.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rep_d   = 1'b0;
      case (state_q)
        IDLE: begin
          rcnt_d = '0;
          if (rise) begin
            rep_d = 1'b1;
            if (REPEAT_EN[i]) state_d = HOLD;
          end
        end
        HOLD: begin
          if (!level_d) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RD_TC) begin
            rep_d   = 1'b1;
            rcnt_d  = '0;
            state_d = RPT;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT: begin
          if (!level_d) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RP_TC) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dcnt_q  <= '0;
        level_q <= 1'b0;
        state_q <= IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        dcnt_q  <= dcnt_d;
        level_q <= level_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= rise;
        rep_q   <= rep_d;
      end
    end

    assign btn_level[i]  = level_q;
    assign btn_pulse[i]  = pulse_q;
    assign btn_repeat[i] = rep_q;
  end

endmodule
